// File: rtl/sysid_pkg.sv
// ============================================================================
// sysid_pkg : register map, bit positions and helpers for the sysid/uptime slave
// Revision  : 1.0
// ============================================================================
`default_nettype none

package sysid_pkg;

    localparam logic [2:0] SYSID_ADDR_ID        = 3'd0;
    localparam logic [2:0] SYSID_ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] SYSID_ADDR_SCRATCH   = 3'd2;
    localparam logic [2:0] SYSID_ADDR_UPTIME_LO = 3'd3;
    localparam logic [2:0] SYSID_ADDR_UPTIME_HI = 3'd4;
    localparam logic [2:0] SYSID_ADDR_CONTROL   = 3'd5;
    localparam logic [2:0] SYSID_ADDR_STATUS    = 3'd6;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_FREEZE_BIT = 1;
    localparam int STATUS_WRAP_BIT = 0;

    typedef logic [63:0] uptime_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sysid_uptime_counter.sv
// ============================================================================
// sysid_uptime_counter : 64-bit uptime counter with clear/load/freeze, sticky
//                        wrap flag and HI snapshot for coherent two-word reads
// Revision             : 1.0
// ============================================================================
`default_nettype none

module sysid_uptime_counter
    import sysid_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_control,
    input  logic        wr_status,
    input  logic        rd_lo,
    input  logic [31:0] writedata,
    output logic [31:0] cnt_lo,
    output logic [31:0] hi_snap,
    output logic        freeze,
    output logic        wrap
);

    uptime_t     r_cnt;
    uptime_t     w_cnt_next;
    logic [31:0] r_hi_snap;
    logic        r_freeze;
    logic        r_wrap;
    logic        w_clear;
    logic        w_wrap_event;

    // Clear beats a load, a load beats the increment; a load leaves the other half untouched.
    always_comb begin
        w_clear      = wr_control & writedata[CTRL_CLEAR_BIT];
        w_wrap_event = 1'b0;
        w_cnt_next   = r_cnt;
        if (w_clear) begin
            w_cnt_next = '0;
        end else if (wr_lo) begin
            w_cnt_next = {r_cnt[63:32], writedata};
        end else if (wr_hi) begin
            w_cnt_next = {writedata, r_cnt[31:0]};
        end else if (!r_freeze) begin
            w_cnt_next   = r_cnt + 64'd1;
            w_wrap_event = &r_cnt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_hi_snap <= '0;
            r_freeze  <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (wr_control) begin
                r_freeze <= writedata[CTRL_FREEZE_BIT];
            end
            if (w_wrap_event) begin
                r_wrap <= 1'b1;
            end else if (wr_status && writedata[STATUS_WRAP_BIT]) begin
                r_wrap <= 1'b0;
            end
            if (rd_lo) begin
                r_hi_snap <= r_cnt[63:32];
            end
        end
    end

    assign cnt_lo  = r_cnt[31:0];
    assign hi_snap = r_hi_snap;
    assign freeze  = r_freeze;
    assign wrap    = r_wrap;

endmodule

`default_nettype wire

// File: rtl/nios_system_sysid_ext.sv
// ============================================================================
// nios_system_sysid_ext : Avalon-MM system-ID, scratch and uptime slave with
//                         fixed-latency pipelined reads. Uptime block is built
//                         only when SYSID_UPTIME_EN is defined.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module nios_system_sysid_ext
    import sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE     = 32'h5805_6E47,
    parameter logic [31:0] TIMESTAMP    = 32'h0,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic [31:0] r_scratch;
    logic [31:0] w_rd_data;
    logic        r_valid_s0;
    logic [31:0] r_data_s0;

`ifdef SYSID_UPTIME_EN
    logic [31:0] w_cnt_lo;
    logic [31:0] w_hi_snap;
    logic        w_freeze;
    logic        w_wrap;

    sysid_uptime_counter u_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_lo      (write && (address == SYSID_ADDR_UPTIME_LO)),
        .wr_hi      (write && (address == SYSID_ADDR_UPTIME_HI)),
        .wr_control (write && (address == SYSID_ADDR_CONTROL)),
        .wr_status  (write && (address == SYSID_ADDR_STATUS)),
        .rd_lo      (read  && (address == SYSID_ADDR_UPTIME_LO)),
        .writedata  (writedata),
        .cnt_lo     (w_cnt_lo),
        .hi_snap    (w_hi_snap),
        .freeze     (w_freeze),
        .wrap       (w_wrap)
    );
`endif

    // Sampled from current state, so a same-cycle write is not visible to the read.
    always_comb begin
        w_rd_data = '0;
        case (address)
            SYSID_ADDR_ID:        w_rd_data = ID_VALUE;
            SYSID_ADDR_TIMESTAMP: w_rd_data = TIMESTAMP;
            SYSID_ADDR_SCRATCH:   w_rd_data = r_scratch;
`ifdef SYSID_UPTIME_EN
            SYSID_ADDR_UPTIME_LO: w_rd_data = w_cnt_lo;
            SYSID_ADDR_UPTIME_HI: w_rd_data = w_hi_snap;
            SYSID_ADDR_CONTROL:   w_rd_data = {30'd0, w_freeze, 1'b0};
            SYSID_ADDR_STATUS:    w_rd_data = {31'd0, w_wrap};
`endif
            default:              w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch  <= '0;
            r_valid_s0 <= 1'b0;
            r_data_s0  <= '0;
        end else begin
            if (write && (address == SYSID_ADDR_SCRATCH)) begin
                r_scratch <= merge_bytes(r_scratch, writedata, byteenable);
            end
            r_valid_s0 <= read;
            r_data_s0  <= read ? w_rd_data : 32'd0;
        end
    end

    if (READ_LATENCY >= 2) begin : g_lat2
        logic        r_valid_s1;
        logic [31:0] r_data_s1;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_valid_s1 <= 1'b0;
                r_data_s1  <= '0;
            end else begin
                r_valid_s1 <= r_valid_s0;
                r_data_s1  <= r_data_s0;
            end
        end

        assign readdatavalid = r_valid_s1;
        assign readdata      = r_data_s1;
    end else begin : g_lat1
        assign readdatavalid = r_valid_s0;
        assign readdata      = r_data_s0;
    end

endmodule

`default_nettype wire
